// File: rtl/pc_sel_unit_if.sv
// Bus between the PC unit and its controller: write enable, source select, sources,
// interrupt inputs, and the PC, MEPC and status outputs. Signal prefixes are from the unit's view.
interface pc_sel_unit_if #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 6
);
    logic                   i_pcWe;
    logic [3:0]             i_pcSel;
    logic [NSRC*WIDTH-1:0]  i_dSrc;
    logic                   i_intr;
    logic [WIDTH-1:0]       i_mtvec;
    logic [WIDTH-1:0]       o_pc;
    logic [WIDTH-1:0]       o_pcPlus4;
    logic [WIDTH-1:0]       o_mepc;
    logic                   o_intrTaken;
    logic                   o_selErr;
    logic                   o_misalign;

    modport master (
        output i_pcWe, i_pcSel, i_dSrc, i_intr, i_mtvec,
        input  o_pc, o_pcPlus4, o_mepc, o_intrTaken, o_selErr, o_misalign
    );

    modport slave (
        input  i_pcWe, i_pcSel, i_dSrc, i_intr, i_mtvec,
        output o_pc, o_pcPlus4, o_mepc, o_intrTaken, o_selErr, o_misalign
    );
endinterface

// File: rtl/pc_sel_unit.sv
// PC unit: N-way next-PC select, PC register, PC+4, interrupt redirect with MEPC capture.
// Optional macro PC_ALIGN_CHECK_EN suppresses non-interrupt loads to targets with bits [1:0] != 0.
module pc_sel_unit #(
    parameter int               WIDTH   = 32,
    parameter int               NSRC    = 6,
    parameter logic [WIDTH-1:0] RST_VEC = '0
) (
    input logic          i_clk,
    input logic          i_rst,
    pc_sel_unit_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, PEND = 1'b1} pendState_t;

    localparam logic [4:0] NSRC_L = 5'(NSRC);

    pendState_t       r_pend;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_mepc;
    logic             r_intrQ;
    logic             r_intrTaken;
    logic             r_selErr;

    logic [WIDTH-1:0] w_pcPlus4;
    logic [WIDTH-1:0] w_cand;
    logic             w_selLegal;
    logic             w_intrRise;
    logic             w_take;
    logic             w_targetBad;
    logic             w_unusedSlot0;

    assign w_pcPlus4     = r_pc + {{(WIDTH-3){1'b0}}, 3'd4};
    assign w_selLegal    = ({1'b0, bus.i_pcSel} < NSRC_L);
    assign w_intrRise    = bus.i_intr & ~r_intrQ;
    assign w_take        = bus.i_pcWe & (r_pend == PEND);
    assign w_unusedSlot0 = ^bus.i_dSrc[WIDTH-1:0];

    // Slot 0 of the flattened source bus is replaced by the internal incrementer.
    always_comb begin
        w_cand = w_pcPlus4;
        for (int k = 1; k < NSRC; k++) begin
            if (bus.i_pcSel == 4'(k)) begin
                w_cand = bus.i_dSrc[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc        <= RST_VEC;
            r_mepc      <= '0;
            r_pend      <= IDLE;
            r_intrQ     <= 1'b0;
            r_intrTaken <= 1'b0;
            r_selErr    <= 1'b0;
        end else begin
            r_intrQ     <= bus.i_intr;
            r_intrTaken <= w_take;
            // A fresh edge in the take cycle keeps the interrupt pending.
            if (w_intrRise) begin
                r_pend <= PEND;
            end else if (w_take) begin
                r_pend <= IDLE;
            end
            if (bus.i_pcWe) begin
                if (!w_selLegal) begin
                    r_selErr <= 1'b1;
                end
                if (w_take) begin
                    r_pc   <= bus.i_mtvec;
                    r_mepc <= w_selLegal ? w_cand : w_pcPlus4;
                end else if (w_selLegal && !w_targetBad) begin
                    r_pc <= w_cand;
                end
            end
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic r_misalign;

    assign w_targetBad = |w_cand[1:0];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_misalign <= 1'b0;
        end else if (bus.i_pcWe && !w_take && w_selLegal && w_targetBad) begin
            r_misalign <= 1'b1;
        end
    end

    assign bus.o_misalign = r_misalign;
`else
    assign w_targetBad    = 1'b0;
    assign bus.o_misalign = 1'b0;
`endif

    assign bus.o_pc        = r_pc;
    assign bus.o_pcPlus4   = w_pcPlus4;
    assign bus.o_mepc      = r_mepc;
    assign bus.o_intrTaken = r_intrTaken;
    assign bus.o_selErr    = r_selErr;
endmodule

// File: tb/tb_pc_sel_unit.sv
// Directed testbench for pc_sel_unit (WIDTH=32, NSRC=6, RST_VEC=0x100).
// Expected values are hand-computed; alignment expectations follow PC_ALIGN_CHECK_EN.
module tb_pc_sel_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nVec  = 0;
    int   nMiss = 0;

    pc_sel_unit_if #(.WIDTH(32), .NSRC(6)) bus ();

    pc_sel_unit #(.WIDTH(32), .NSRC(6), .RST_VEC(32'h100)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.i_pcWe = 1'b0; bus.i_pcSel = 4'd0; bus.i_dSrc = '0; bus.i_intr = 1'b0; bus.i_mtvec = '0;
        rst = 1'b1;
        #12;
        nVec++; if (bus.o_pc !== 32'h100) begin nMiss++; $display("[TB] FAIL reset_pc: got %h want %h", bus.o_pc, 32'h100); end
        nVec++; if (bus.o_mepc !== 32'h0) begin nMiss++; $display("[TB] FAIL reset_mepc: got %h want %h", bus.o_mepc, 32'h0); end
        nVec++; if ({bus.o_intrTaken, bus.o_selErr, bus.o_misalign} !== 3'b000) begin nMiss++; $display("[TB] FAIL reset_flags: got %b want 000", {bus.o_intrTaken, bus.o_selErr, bus.o_misalign}); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_increment();
        logic [31:0] expPc;
        bus.i_pcWe = 1'b1; bus.i_pcSel = 4'd0;
        expPc = 32'h100;
        for (int i = 0; i < 3; i++) begin
            step();
            expPc = expPc + 32'd4;
            nVec++; if (bus.o_pc !== expPc) begin nMiss++; $display("[TB] FAIL inc_pc[%0d]: got %h want %h", i, bus.o_pc, expPc); end
            nVec++; if (bus.o_pcPlus4 !== expPc + 32'd4) begin nMiss++; $display("[TB] FAIL inc_plus4[%0d]: got %h want %h", i, bus.o_pcPlus4, expPc + 32'd4); end
        end
    endtask

    task automatic test_select_hold();
        bus.i_dSrc[3*32 +: 32] = 32'h2000;
        bus.i_pcSel = 4'd3; bus.i_pcWe = 1'b1;
        step();
        nVec++; if (bus.o_pc !== 32'h2000) begin nMiss++; $display("[TB] FAIL sel3_pc: got %h want %h", bus.o_pc, 32'h2000); end
        bus.i_pcWe = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            nVec++; if (bus.o_pc !== 32'h2000) begin nMiss++; $display("[TB] FAIL hold_pc[%0d]: got %h want %h", i, bus.o_pc, 32'h2000); end
        end
        bus.i_dSrc[2*32 +: 32] = 32'hFFFF_FFFC;
        bus.i_pcSel = 4'd2; bus.i_pcWe = 1'b1;
        step();
        nVec++; if (bus.o_pc !== 32'hFFFF_FFFC) begin nMiss++; $display("[TB] FAIL wrap_pc: got %h want %h", bus.o_pc, 32'hFFFF_FFFC); end
        nVec++; if (bus.o_pcPlus4 !== 32'h0) begin nMiss++; $display("[TB] FAIL wrap_plus4: got %h want %h", bus.o_pcPlus4, 32'h0); end
        bus.i_pcSel = 4'd0;
        step();
        nVec++; if (bus.o_pc !== 32'h0) begin nMiss++; $display("[TB] FAIL wrap_next_pc: got %h want %h", bus.o_pc, 32'h0); end
    endtask

    task automatic test_illegal_sel();
        bus.i_dSrc[1*32 +: 32] = 32'h40;
        bus.i_pcSel = 4'd1; bus.i_pcWe = 1'b1;
        step();
        nVec++; if (bus.o_pc !== 32'h40) begin nMiss++; $display("[TB] FAIL ill_setup_pc: got %h want %h", bus.o_pc, 32'h40); end
        nVec++; if (bus.o_selErr !== 1'b0) begin nMiss++; $display("[TB] FAIL ill_setup_err: got %b want 0", bus.o_selErr); end
        bus.i_pcSel = 4'd7;
        step();
        nVec++; if (bus.o_pc !== 32'h40) begin nMiss++; $display("[TB] FAIL ill_pc: got %h want %h", bus.o_pc, 32'h40); end
        nVec++; if (bus.o_selErr !== 1'b1) begin nMiss++; $display("[TB] FAIL ill_err: got %b want 1", bus.o_selErr); end
        bus.i_pcSel = 4'd0;
        step();
        nVec++; if (bus.o_pc !== 32'h44) begin nMiss++; $display("[TB] FAIL ill_after_pc: got %h want %h", bus.o_pc, 32'h44); end
        nVec++; if (bus.o_selErr !== 1'b1) begin nMiss++; $display("[TB] FAIL ill_sticky_err: got %b want 1", bus.o_selErr); end
    endtask

    task automatic test_interrupt();
        bus.i_dSrc[1*32 +: 32] = 32'h80;
        bus.i_pcSel = 4'd1; bus.i_pcWe = 1'b1; bus.i_mtvec = 32'h400;
        step();
        nVec++; if (bus.o_pc !== 32'h80) begin nMiss++; $display("[TB] FAIL irq_setup_pc: got %h want %h", bus.o_pc, 32'h80); end
        bus.i_pcWe = 1'b0; bus.i_intr = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            nVec++; if (bus.o_pc !== 32'h80) begin nMiss++; $display("[TB] FAIL irq_wait_pc[%0d]: got %h want %h", i, bus.o_pc, 32'h80); end
            nVec++; if (bus.o_intrTaken !== 1'b0) begin nMiss++; $display("[TB] FAIL irq_wait_taken[%0d]: got %b want 0", i, bus.o_intrTaken); end
        end
        bus.i_pcWe = 1'b1; bus.i_pcSel = 4'd0;
        step();
        nVec++; if (bus.o_pc !== 32'h400) begin nMiss++; $display("[TB] FAIL irq_take_pc: got %h want %h", bus.o_pc, 32'h400); end
        nVec++; if (bus.o_mepc !== 32'h84) begin nMiss++; $display("[TB] FAIL irq_mepc: got %h want %h", bus.o_mepc, 32'h84); end
        nVec++; if (bus.o_intrTaken !== 1'b1) begin nMiss++; $display("[TB] FAIL irq_taken: got %b want 1", bus.o_intrTaken); end
        step();
        nVec++; if (bus.o_pc !== 32'h404) begin nMiss++; $display("[TB] FAIL irq_after_pc: got %h want %h", bus.o_pc, 32'h404); end
        nVec++; if (bus.o_intrTaken !== 1'b0) begin nMiss++; $display("[TB] FAIL irq_pulse_end: got %b want 0", bus.o_intrTaken); end
        step();
        nVec++; if (bus.o_pc !== 32'h408) begin nMiss++; $display("[TB] FAIL irq_no_retake_pc: got %h want %h", bus.o_pc, 32'h408); end
        nVec++; if (bus.o_mepc !== 32'h84) begin nMiss++; $display("[TB] FAIL irq_mepc_hold: got %h want %h", bus.o_mepc, 32'h84); end
        bus.i_intr = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        bus.i_pcWe = 1'b0; bus.i_intr = 1'b1;
        step();
        #3;
        rst = 1'b1;
        #1;
        nVec++; if (bus.o_pc !== 32'h100) begin nMiss++; $display("[TB] FAIL arst_pc: got %h want %h", bus.o_pc, 32'h100); end
        nVec++; if (bus.o_mepc !== 32'h0) begin nMiss++; $display("[TB] FAIL arst_mepc: got %h want %h", bus.o_mepc, 32'h0); end
        nVec++; if ({bus.o_intrTaken, bus.o_selErr, bus.o_misalign} !== 3'b000) begin nMiss++; $display("[TB] FAIL arst_flags: got %b want 000", {bus.o_intrTaken, bus.o_selErr, bus.o_misalign}); end
        bus.i_intr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bus.i_pcWe = 1'b1; bus.i_pcSel = 4'd0;
        step();
        nVec++; if (bus.o_pc !== 32'h104) begin nMiss++; $display("[TB] FAIL arst_no_irq_pc: got %h want %h", bus.o_pc, 32'h104); end
        nVec++; if (bus.o_intrTaken !== 1'b0) begin nMiss++; $display("[TB] FAIL arst_no_irq_taken: got %b want 0", bus.o_intrTaken); end
        step();
        nVec++; if (bus.o_pc !== 32'h108) begin nMiss++; $display("[TB] FAIL arst_next_pc: got %h want %h", bus.o_pc, 32'h108); end
    endtask

    task automatic test_align();
        logic [31:0] expPc;
        logic        expMis;
        bus.i_dSrc[1*32 +: 32] = 32'h10;
        bus.i_pcSel = 4'd1; bus.i_pcWe = 1'b1;
        step();
        nVec++; if (bus.o_pc !== 32'h10) begin nMiss++; $display("[TB] FAIL align_setup_pc: got %h want %h", bus.o_pc, 32'h10); end
        bus.i_dSrc[1*32 +: 32] = 32'h202;
        step();
`ifdef PC_ALIGN_CHECK_EN
        expPc = 32'h10; expMis = 1'b1;
`else
        expPc = 32'h202; expMis = 1'b0;
`endif
        nVec++; if (bus.o_pc !== expPc) begin nMiss++; $display("[TB] FAIL align_pc: got %h want %h", bus.o_pc, expPc); end
        nVec++; if (bus.o_misalign !== expMis) begin nMiss++; $display("[TB] FAIL align_flag: got %b want %b", bus.o_misalign, expMis); end
        nVec++; if (bus.o_selErr !== 1'b0) begin nMiss++; $display("[TB] FAIL align_selerr: got %b want 0", bus.o_selErr); end
        bus.i_pcWe = 1'b0;
    endtask

    initial begin
        test_reset();
        test_increment();
        test_select_hold();
        test_illegal_sel();
        test_interrupt();
        test_async_reset();
        test_align();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end
endmodule

// File: doc/pc_sel_unit.md
Name: pc_sel_unit

Overview:
- Parametrised program-counter unit: N-way next-PC source select plus the PC register itself.
- Adds a PC+4 incrementer, interrupt-vector redirect with saved-PC capture, and a sticky illegal-select flag.
- Sits between the branch/jump target generators and instruction-memory address input. Replaces the stand-alone combinational PC source mux plus the separate PC register.

Parameters:
- WIDTH, 32, PC and source data width in bits (≥ 3).
- NSRC, 6, number of selectable next-PC sources including internal PC+4 at index 0 (2..16).
- RST_VEC, 0, PC value loaded on reset.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- PC_WE  input  1  PC write enable; PC updates only on cycles where it is high.
- PC_SEL  input  4  next-PC source index.
- D_SRC  input  NSRC*WIDTH  flattened sources, slot k = bits [k*WIDTH +: WIDTH]; slot 0 ignored.
- INTR  input  1  interrupt request, level input, edge-detected internally.
- MTVEC  input  WIDTH  interrupt target address.
- PC  output  WIDTH  current program counter.
- PC_PLUS4  output  WIDTH  PC + 4, combinational, modulo 2^WIDTH.
- MEPC  output  WIDTH  next-PC that was displaced by the last taken interrupt.
- INTR_TAKEN  output  1  one-cycle pulse on the cycle after the interrupt redirect.
- SEL_ERR  output  1  sticky illegal-select flag.
- MISALIGN  output  1  sticky misaligned-target flag (see Optional Feature).

Behaviour:
- Reset (async, RST=1): PC=RST_VEC, MEPC=0, INTR_TAKEN=0, SEL_ERR=0, MISALIGN=0, pending=0, INTR edge register=0.
- Reset is honoured mid-operation, including while an interrupt is pending; the pending interrupt is discarded.
- Candidate next-PC: index 0 = PC_PLUS4; index k in 1..NSRC-1 = D_SRC slot k.
- PC_SEL ≥ NSRC is illegal. With PC_WE=1 and an illegal select, PC holds and SEL_ERR is set. SEL_ERR clears only on reset.
- Interrupt pending latch:
  - Set on the rising edge of INTR, detected against a registered copy of INTR.
  - Cleared when the interrupt is taken.
  - A new rising edge in the same cycle as a take leaves pending set (set wins).
- Take rule: PC_WE=1 and pending=1.
  - PC <= MTVEC.
  - MEPC <= candidate next-PC. If PC_SEL is illegal, MEPC <= PC_PLUS4 instead.
  - INTR_TAKEN=1 for exactly the next cycle.
  - Interrupt priority exceeds every source; SEL_ERR is still set if PC_SEL is illegal.
- PC_WE=0: PC, MEPC and all flags hold. A pending interrupt waits. INTR_TAKEN=0.
- Latency: the selected value appears on PC one clock after the PC_WE edge. No combinational path from PC_SEL or D_SRC to PC.
- PC+4 wraps: PC = 2^WIDTH-4 gives PC_PLUS4 = 0.
- Each state machine is a single bit: pending (IDLE/PEND) and the take pulse register.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - A non-interrupt load whose target has bits [1:0] ≠ 0 is suppressed: PC holds and MISALIGN is set sticky until reset.
  - MTVEC is not checked; an interrupt take always loads it.
  - Illegal select takes precedence over misalignment: only SEL_ERR is set.
- Undefined:
  - Target loaded verbatim.
  - MISALIGN tied 0.

Test Plan:
- Reset with RST_VEC=32'h100, then PC_WE=1, PC_SEL=0 for 3 cycles -> PC = 0x104, 0x108, 0x10C; PC_PLUS4 tracks PC+4.
- PC_SEL=3, slot 3 = 32'h2000, PC_WE=1 -> PC=0x2000 next cycle. Then PC_WE=0 for 2 cycles -> PC holds 0x2000.
- NSRC=6, PC_SEL=7, PC_WE=1 at PC=0x40 -> PC stays 0x40, SEL_ERR=1. Then PC_SEL=0 -> PC=0x44 and SEL_ERR remains 1 until RST.
- PC=0x80, MTVEC=0x400:
  - INTR rises while PC_WE=0 -> PC holds.
  - Then PC_WE=1, PC_SEL=0 -> PC=0x400, MEPC=0x84, INTR_TAKEN high exactly one cycle.
  - INTR held high afterwards -> no second take.
- Assert RST asynchronously mid-cycle with an interrupt pending -> PC=RST_VEC immediately, all flags 0. After release with PC_WE=1 -> no interrupt is taken.
- With PC_ALIGN_CHECK_EN, slot 1 = 0x202 selected at PC=0x10 -> PC stays 0x10, MISALIGN=1. Without the macro, same stimulus -> PC=0x202 and MISALIGN=0.
